// File: rtl/ysyx_ifu_bus_rsp_if.sv
// Fetch-request and AXI4 read-channel signals between the L1I, ysyx_ifu_bus_rsp and the bus arbiter.
// slave: the responder's view. master: the view of the surrounding L1I and AXI fabric.
interface ysyx_ifu_bus_rsp_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ifu_araddr;
    logic            ifu_arvalid;
    logic            ifu_lock;
    logic            ifu_ready;
    logic [XLEN-1:0] ifu_rdata;
    logic            ifu_rvalid;
    logic            ifu_rerr;
    logic            bus_busy;

    logic            m_arvalid;
    logic            m_arready;
    logic [31:0]     m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_rvalid;
    logic            m_rready;
    logic [31:0]     m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;

    modport slave (
        input  ifu_araddr, ifu_arvalid, ifu_lock,
        output ifu_ready, ifu_rdata, ifu_rvalid, ifu_rerr, bus_busy,
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );

    modport master (
        output ifu_araddr, ifu_arvalid, ifu_lock,
        input  ifu_ready, ifu_rdata, ifu_rvalid, ifu_rerr, bus_busy,
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );
endinterface

// File: rtl/ysyx_ifu_bus_rsp.sv
// IFU fetch responder: converts one L1I request into an AXI4 read and returns each beat as a pulse.
// Define YSYX_IFU_RSP_BURST_EN to turn requests in [BURST_BASE, BURST_LIMIT] into 2-beat bursts.
module ysyx_ifu_bus_rsp #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] BURST_BASE  = 32'ha000_0000,
    parameter logic [31:0] BURST_LIMIT = 32'hc000_0000
) (
    input logic               clock,
    input logic               reset,
    ysyx_ifu_bus_rsp_if.slave bus
);

`ifdef YSYX_IFU_RSP_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        R2   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic              burst_q, burst_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;

    logic [31:0]       req_addr;
    logic              burst_sel;
    logic              ifu_ready_c;
    logic              m_arvalid_c;
    logic              m_rready_c;

    assign req_addr  = 32'(bus.ifu_araddr);
    assign burst_sel = BURST_EN && (req_addr >= BURST_BASE) && (req_addr <= BURST_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

    // Request address and mode are only consumed after IDLE has loaded them.
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        burst_q <= burst_d;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        rerr_d      = 1'b0;
        ifu_ready_c = 1'b0;
        m_arvalid_c = 1'b0;
        m_rready_c  = 1'b0;

        case (state_q)
            IDLE: begin
                ifu_ready_c = 1'b1;
                if (bus.ifu_arvalid) begin
                    burst_d = burst_sel;
                    addr_d  = burst_sel ? {req_addr[31:3], 3'b000} : {req_addr[31:2], 2'b00};
                    state_d = AR;
                end
            end
            AR: begin
                m_arvalid_c = 1'b1;
                if (bus.m_arready) begin
                    state_d = R;
                end
            end
            R: begin
                m_rready_c = 1'b1;
                if (bus.m_rvalid) begin
                    rdata_d  = XLEN'(bus.m_rdata);
                    rvalid_d = 1'b1;
                    rerr_d   = |bus.m_rresp;
                    if (!burst_q) begin
                        state_d = IDLE;
                    end else if (bus.m_rlast) begin
                        // Slave ended a 2-beat burst early: flag it, the L1I refetches.
                        state_d = IDLE;
                        rerr_d  = 1'b1;
                    end else begin
                        state_d = R2;
                    end
                end
            end
            R2: begin
                m_rready_c = 1'b1;
                if (bus.m_rvalid) begin
                    rdata_d  = XLEN'(bus.m_rdata);
                    rvalid_d = 1'b1;
                    rerr_d   = |bus.m_rresp;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ifu_ready  = ifu_ready_c;
    assign bus.ifu_rdata  = rdata_q;
    assign bus.ifu_rvalid = rvalid_q;
    assign bus.ifu_rerr   = rerr_q;
    assign bus.bus_busy   = (state_q != IDLE) || bus.ifu_lock;

    assign bus.m_arvalid  = m_arvalid_c;
    assign bus.m_araddr   = addr_q;
    assign bus.m_arlen    = {7'd0, burst_q};
    assign bus.m_arsize   = 3'b010;
    assign bus.m_arburst  = 2'b01;
    assign bus.m_rready   = m_rready_c;

endmodule
